// File: rtl/lamp_fpu_log_arb_pkg.sv
// Shared types and the operand unpack helper for the log-unit arbiter.
package lamp_fpu_log_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lampLogArb_state_t;

  typedef struct packed {
    logic       s;
    logic [8:0] extE;
    logic [7:0] extF;
    logic       isZ;
    logic       isInf;
    logic       isSNAN;
    logic       isQNAN;
  } lampLogOp_t;

  // Split a raw bfloat16 into the extended fields and class flags the log unit expects.
  function automatic lampLogOp_t FUNC_unpackLogOp(input logic [15:0] op);
    lampLogOp_t r;
    logic [7:0] e;
    logic [6:0] f;
    e        = op[14:7];
    f        = op[6:0];
    r.s      = op[15];
    r.extE   = (e == 8'd0) ? 9'd1 : {1'b0, e};
    r.extF   = {|e, f};
    r.isZ    = (e == 8'd0) && (f == 7'd0);
    r.isInf  = (e == 8'hFF) && (f == 7'd0);
    r.isQNAN = (e == 8'hFF) && f[6];
    r.isSNAN = (e == 8'hFF) && !f[6] && (f != 7'd0);
    return r;
  endfunction

endpackage

// File: rtl/lamp_fpu_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module lamp_fpu_rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [ID_W-1:0] cand_s;

  // Walk the requesters in rotated order starting at the pointer, keeping the first hit.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = ID_W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand_s]) begin
        grant_o[cand_s] = 1'b1;
        idx_o           = cand_s;
        any_o           = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/lamp_fpu_log_arb.sv
// Shares one lampFPU_log unit between N_REQ requesters: round-robin grant,
// operand unpack, fixed-latency wait, result capture and return with the owner id.
module lamp_fpu_log_arb
  import lamp_fpu_log_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int LOG_LAT = 3,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ*16-1:0] req_op_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [ID_W-1:0]     res_id_o,
  output logic                res_s_o,
  output logic [7:0]          res_e_o,
  output logic [11:0]         res_f_o,
  output logic                res_isToRound_o,
  output logic                res_isOverflow_o,
  output logic                res_isUnderflow_o,
  output logic                busy_o,
  output logic                doLog_o,
  output logic                s_op_o,
  output logic [8:0]          extE_op1_o,
  output logic [7:0]          extF_op1_o,
  output logic                isZ_op_o,
  output logic                isInf_op_o,
  output logic                isSNAN_op_o,
  output logic                isQNAN_op_o,
  input  logic                s_res_i,
  input  logic [7:0]          e_res_i,
  input  logic [11:0]         f_res_i,
  input  logic                isOverflow_i,
  input  logic                isUnderflow_i,
  input  logic                isToRound_i
);

  localparam int CNT_W = $clog2(LOG_LAT + 1);

  lampLogArb_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  lampLogOp_t        op_q, op_d;
  logic              do_log_q, do_log_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_s_q, res_s_d;
  logic [7:0]        res_e_q, res_e_d;
  logic [11:0]       res_f_q, res_f_d;
  logic              res_rnd_q, res_rnd_d;
  logic              res_ovf_q, res_ovf_d;
  logic              res_unf_q, res_unf_d;

  logic [N_REQ-1:0]  arb_grant_s;
  logic [ID_W-1:0]   arb_idx_s;
  logic              arb_any_s;
  logic [15:0]       op_sel_s;

  lamp_fpu_rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .any_o   (arb_any_s)
  );

  // Grants are only offered in IDLE and never while reset is being applied.
  assign req_ready_o = ((state_q == IDLE) && !rst) ? arb_grant_s : '0;

  // One-hot mux of the winning requester's raw operand.
  always_comb begin
    op_sel_s = 16'd0;
    for (int k = 0; k < N_REQ; k++) begin
      op_sel_s = op_sel_s | (req_op_i[16*k +: 16] & {16{arb_grant_s[k]}});
    end
  end

  // Next-state, counter and register-update logic for the grant/issue/wait/respond sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    do_log_d    = 1'b0;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_s_d     = res_s_q;
    res_e_d     = res_e_q;
    res_f_d     = res_f_q;
    res_rnd_d   = res_rnd_q;
    res_ovf_d   = res_ovf_q;
    res_unf_d   = res_unf_q;
    case (state_q)
      IDLE: begin
        if (arb_any_s) begin
          state_d  = ISSUE;
          op_d     = FUNC_unpackLogOp(op_sel_s);
          id_d     = arb_idx_s;
          ptr_d    = (arb_idx_s == ID_W'(N_REQ - 1)) ? '0 : arb_idx_s + ID_W'(1);
          do_log_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(LOG_LAT);
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d     = RESP;
          cnt_d       = '0;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_s_d     = s_res_i;
          res_e_d     = e_res_i;
          res_f_d     = f_res_i;
          res_rnd_d   = isToRound_i;
          res_ovf_d   = isOverflow_i;
          res_unf_d   = isUnderflow_i;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (res_ready_i) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      do_log_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_s_q     <= 1'b0;
      res_e_q     <= 8'd0;
      res_f_q     <= 12'd0;
      res_rnd_q   <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      do_log_q    <= do_log_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_s_q     <= res_s_d;
      res_e_q     <= res_e_d;
      res_f_q     <= res_f_d;
      res_rnd_q   <= res_rnd_d;
      res_ovf_q   <= res_ovf_d;
      res_unf_q   <= res_unf_d;
    end
  end

  assign doLog_o           = do_log_q;
  assign busy_o            = busy_q;
  assign s_op_o            = op_q.s;
  assign extE_op1_o        = op_q.extE;
  assign extF_op1_o        = op_q.extF;
  assign isZ_op_o          = op_q.isZ;
  assign isInf_op_o        = op_q.isInf;
  assign isSNAN_op_o       = op_q.isSNAN;
  assign isQNAN_op_o       = op_q.isQNAN;
  assign res_valid_o       = res_valid_q;
  assign res_id_o          = res_id_q;
  assign res_s_o           = res_s_q;
  assign res_e_o           = res_e_q;
  assign res_f_o           = res_f_q;
  assign res_isToRound_o   = res_rnd_q;
  assign res_isOverflow_o  = res_ovf_q;
  assign res_isUnderflow_o = res_unf_q;

endmodule
